// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-read-port register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef logic [DATA_W_DEF-1:0] reg_word_t;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: enable with output hold, write-bypass compare and a read-valid flag.
module reg_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;

  // wr_fire is already cleared for discarded zero-register writes, so they never forward.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      if (BYPASS != 0 && wr_fire && wr_addr == rd_addr) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_file_mrp.sv
// Register file with one synchronous write port and NUM_RD registered read ports.
module reg_file_mrp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WrAdd,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [NUM_RD-1:0]        RdEn,
  input  logic [NUM_RD*ADDR_W-1:0] ReadAdd,
  output logic [NUM_RD*DATA_W-1:0] Output,
  output logic [NUM_RD-1:0]        RdValid
);

  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_d [MEM_DEPTH];
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic              wr_fire;

  // Entry 0 never takes a write when hardwired, so it stays at its reset value of 0.
  always_comb begin
    wr_fire = WrEn;
    if (ZERO_REG != 0 && WrAdd == '0) begin
      wr_fire = 1'b0;
    end
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[WrAdd] = WrData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = ReadAdd[p*ADDR_W +: ADDR_W];

    reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .clk      (Clock),
      .rst      (Reset),
      .rd_en    (RdEn[p]),
      .rd_addr  (rd_addr),
      .rd_word  (mem_q[rd_addr]),
      .wr_fire  (wr_fire),
      .wr_addr  (WrAdd),
      .wr_data  (WrData),
      .rd_data  (Output[p*DATA_W +: DATA_W]),
      .rd_valid (RdValid[p])
    );
  end

endmodule

// File: tb/tb_reg_file_mrp.sv
// Bench for reg_file_mrp: default build (bypass, zero reg) and a 16x8, 4-port build without either.
module tb_reg_file_mrp;

  localparam int A_DW = 32, A_AW = 5, A_NR = 2, A_ZR = 1, A_BY = 1;
  localparam int B_DW = 16, B_AW = 3, B_NR = 4, B_ZR = 0, B_BY = 0;

  logic Clock = 1'b0;
  logic rst;

  logic                 a_we;
  logic [A_AW-1:0]      a_wa;
  logic [A_DW-1:0]      a_wd;
  logic [A_NR-1:0]      a_re;
  logic [A_NR*A_AW-1:0] a_ra;
  logic [A_NR*A_DW-1:0] a_out;
  logic [A_NR-1:0]      a_vld;

  logic                 b_we;
  logic [B_AW-1:0]      b_wa;
  logic [B_DW-1:0]      b_wd;
  logic [B_NR-1:0]      b_re;
  logic [B_NR*B_AW-1:0] b_ra;
  logic [B_NR*B_DW-1:0] b_out;
  logic [B_NR-1:0]      b_vld;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  reg_file_mrp #(.DATA_W(A_DW), .ADDR_W(A_AW), .NUM_RD(A_NR), .ZERO_REG(A_ZR), .BYPASS(A_BY)) dut_a (
    .Clock(Clock), .Reset(rst), .WrEn(a_we), .WrAdd(a_wa), .WrData(a_wd),
    .RdEn(a_re), .ReadAdd(a_ra), .Output(a_out), .RdValid(a_vld)
  );

  reg_file_mrp #(.DATA_W(B_DW), .ADDR_W(B_AW), .NUM_RD(B_NR), .ZERO_REG(B_ZR), .BYPASS(B_BY)) dut_b (
    .Clock(Clock), .Reset(rst), .WrEn(b_we), .WrAdd(b_wa), .WrData(b_wd),
    .RdEn(b_re), .ReadAdd(b_ra), .Output(b_out), .RdValid(b_vld)
  );

  // Reference model: plain arrays updated by the read-then-write rules at each rising edge.
  logic [A_DW-1:0] ma [1<<A_AW];
  logic [A_DW-1:0] ea [A_NR];
  logic [A_NR-1:0] va;
  logic [B_DW-1:0] mb [1<<B_AW];
  logic [B_DW-1:0] eb [B_NR];
  logic [B_NR-1:0] vb;

  always @(posedge Clock) begin
    int addr;
    bit a_keep, b_keep;
    if (rst) begin
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;
      foreach (ea[i]) ea[i] = '0;
      foreach (eb[i]) eb[i] = '0;
      va = '0;
      vb = '0;
    end else begin
      a_keep = a_we && !(A_ZR != 0 && a_wa == 0);
      b_keep = b_we && !(B_ZR != 0 && b_wa == 0);
      for (int p = 0; p < A_NR; p++) begin
        va[p] = a_re[p];
        if (a_re[p]) begin
          addr  = int'(a_ra[p*A_AW +: A_AW]);
          ea[p] = (A_BY != 0 && a_keep && int'(a_wa) == addr) ? a_wd : ma[addr];
        end
      end
      for (int p = 0; p < B_NR; p++) begin
        vb[p] = b_re[p];
        if (b_re[p]) begin
          addr  = int'(b_ra[p*B_AW +: B_AW]);
          eb[p] = (B_BY != 0 && b_keep && int'(b_wa) == addr) ? b_wd : mb[addr];
        end
      end
      if (a_keep) ma[a_wa] = a_wd;
      if (b_keep) mb[b_wa] = b_wd;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    for (int p = 0; p < A_NR; p++) begin
      check_eq($sformatf("a_data%0d", p), 64'(a_out[p*A_DW +: A_DW]), 64'(ea[p]));
      check_eq($sformatf("a_vld%0d", p), 64'(a_vld[p]), 64'(va[p]));
    end
    for (int p = 0; p < B_NR; p++) begin
      check_eq($sformatf("b_data%0d", p), 64'(b_out[p*B_DW +: B_DW]), 64'(eb[p]));
      check_eq($sformatf("b_vld%0d", p), 64'(b_vld[p]), 64'(vb[p]));
    end
  endtask

  task automatic idle();
    a_we = 0; a_re = '0; b_we = 0; b_re = '0;
  endtask

  initial begin
    rst = 1; idle();
    a_wa = '0; a_wd = '0; a_ra = '0; b_wa = '0; b_wd = '0; b_ra = '0;
    tick(); tick();
    check_eq("rst_out_a", 64'(a_out), 64'd0);
    check_eq("rst_vld_a", 64'(a_vld), 64'd0);
    rst = 0;

    // Every entry reads back zero after reset.
    for (int i = 0; i < 32; i++) begin
      a_re = 2'b11; a_ra = {5'(i), 5'(i)};
      b_re = 4'hF;  b_ra = {4{3'(i)}};
      tick();
      check_eq("t1_zero", 64'(a_out), 64'd0);
      check_eq("t1_vld", 64'(a_vld), 64'd3);
    end

    // Write then read back; write to entry 0 is dropped.
    idle(); a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF; tick();
    idle(); a_re = 2'b01; a_ra = 10'd5; tick();
    check_eq("t2_rd5", 64'(a_out[31:0]), 64'hDEADBEEF);
    check_eq("t2_vld0", 64'(a_vld), 64'd1);
    idle(); a_we = 1; a_wa = 0; a_wd = 32'h12345678; tick();
    idle(); a_re = 2'b10; a_ra = 10'd0; tick();
    check_eq("t2_zreg", 64'(a_out[63:32]), 64'd0);

    // Same-cycle write/read: bypass on build A, old value on build B.
    idle(); a_we = 1; a_wa = 7; a_wd = 32'h11111111; b_we = 1; b_wa = 7; b_wd = 16'h1111; tick();
    a_wd = 32'h22222222; a_re = 2'b01; a_ra = 10'd7;
    b_wd = 16'h2222;     b_re = 4'b0001; b_ra = 12'd7;
    tick();
    check_eq("t3_bypass", 64'(a_out[31:0]), 64'h22222222);
    check_eq("t3_nobypass", 64'(b_out[15:0]), 64'h1111);
    idle(); b_re = 4'b0001; tick();
    check_eq("t3_after", 64'(b_out[15:0]), 64'h2222);

    // Hold: port 1 keeps its data while disabled.
    idle(); a_we = 1; a_wa = 3; a_wd = 32'hA5A5A5A5; tick();
    idle(); a_re = 2'b10; a_ra = {5'd3, 5'd0}; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); a_we = 1; a_wa = 3; a_wd = 32'h0; a_ra = {5'(i + 10), 5'd0};
      tick();
      check_eq("t4_hold", 64'(a_out[63:32]), 64'hA5A5A5A5);
      check_eq("t4_vld", 64'(a_vld[1]), 64'd0);
    end

    // Concurrent ports on one entry, then reset wins over a write.
    idle(); a_we = 1; a_wa = 9; a_wd = 32'h99; tick();
    idle(); a_re = 2'b11; a_ra = {5'd9, 5'd9}; tick();
    check_eq("t5_both", 64'(a_out), {32'h99, 32'h99});
    idle(); rst = 1; a_we = 1; a_wa = 9; a_wd = 32'h55; tick();
    check_eq("t5_rst_out", 64'(a_out), 64'd0);
    check_eq("t5_rst_vld", 64'(a_vld), 64'd0);
    rst = 0; idle(); a_re = 2'b01; a_ra = 10'd9; tick();
    check_eq("t5_lost", 64'(a_out[31:0]), 64'd0);

    // Narrow build: fill all 8 entries, then four ports read 0..3 together.
    for (int i = 0; i < 8; i++) begin
      idle(); b_we = 1; b_wa = 3'(i); b_wd = 16'(16'h1357 * (i + 1)); tick();
    end
    idle(); b_re = 4'hF; b_ra = {3'd3, 3'd2, 3'd1, 3'd0}; tick();
    for (int p = 0; p < 4; p++)
      check_eq($sformatf("t6_port%0d", p), 64'(b_out[p*16 +: 16]), 64'(16'(16'h1357 * (p + 1))));

    // Randomized traffic with address bias to provoke collisions and entry 0.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      a_we = 1'($urandom); a_re = 2'($urandom); a_wd = $urandom;
      a_wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_ra = ($urandom_range(0, 1) != 0) ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))} : 10'($urandom);
      b_we = 1'($urandom); b_re = 4'($urandom); b_wd = 16'($urandom);
      b_wa = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      b_ra = 12'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
